// File: rtl/lsu_swc_pkg.sv
// Shared definitions for the lsu_ahb_swc load/store unit.
// Contents: access-size encodings, AHB-Lite HTRANS/HBURST constants, the FSM
// state enum, and an alignment helper used when a request is accepted.
package lsu_swc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_WB   = 2'b11
  } lsu_state_t;

  // Natural alignment check; the illegal size encoding never passes.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] ea_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (ea_lo[0] == 1'b0);
      SZ_WORD: ok = (ea_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_swc.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   size       access size (byte/half/word)
//   ea_lo      low two bits of the effective address
//   sext       1 = sign-extend the extracted load value
//   store_data right-aligned store data from the EXU
//   rdata      raw AHB read data
//   store_rep  store data replicated across all byte lanes
//   load_val   selected lane of rdata, zero/sign extended to 32 bits
module lsu_lane_swc
  import lsu_swc_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ea_lo,
  input  logic        sext,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] store_rep,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Replication lets the slave pick the lane from haddr, so no byte strobes
  // are needed on the bus.
  always_comb begin
    store_rep = store_data;
    case (size)
      SZ_BYTE: store_rep = {4{store_data[7:0]}};
      SZ_HALF: store_rep = {2{store_data[15:0]}};
      default: store_rep = store_data;
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (ea_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];

    load_val = rdata;
    case (size)
      SZ_BYTE: load_val = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{sext & half_sel[15]}}, half_sel};
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ahb_swc.sv
// Load/store unit: turns one-cycle EXU load/store requests into single
// AHB-Lite transfers, steers byte lanes, extends load data and writes the
// result back to the register file.
// Ports:
//   hclk, hrst            clock, asynchronous active-high reset
//   exu_load_*            load request (ea = base + offset)
//   exu_store_*           store request (store wins if both pulse together)
//   haddr..hwdata         AHB-Lite master outputs (all registered)
//   hrdata, hready, hresp AHB-Lite slave responses
//   lsu_reg_*             register-file writeback
//   lsu_busy              high while a transfer is in flight; EXU must stall
//   lsu_misalign          pulse: misaligned / illegal-size request dropped
//   lsu_bus_err           pulse: error response in data phase
module lsu_ahb_swc
  import lsu_swc_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic            exu_load_en,
  input  logic [4:0]      exu_load_rd,
  input  logic [XLEN-1:0] exu_load_base_addr,
  input  logic [XLEN-1:0] exu_load_offset,
  input  logic            exu_load_sext,
  input  logic [1:0]      exu_load_size,
  input  logic            exu_store_en,
  input  logic [XLEN-1:0] exu_store_addr,
  input  logic [XLEN-1:0] exu_store_data,
  input  logic [1:0]      exu_store_size,
  output logic [XLEN-1:0] haddr,
  output logic [1:0]      htrans,
  output logic            hwrite,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic [3:0]      hprot,
  output logic [XLEN-1:0] hwdata,
  input  logic [XLEN-1:0] hrdata,
  input  logic            hready,
  input  logic            hresp,
  output logic [4:0]      lsu_reg_waddr,
  output logic [XLEN-1:0] lsu_reg_wdata,
  output logic            lsu_reg_wen,
  output logic            lsu_busy,
  output logic            lsu_misalign,
  output logic            lsu_bus_err
);

  lsu_state_t state;

  // Request decode at acceptance; the store takes priority over the load.
  logic            req_valid;
  logic            req_store;
  logic [XLEN-1:0] req_ea;
  logic [1:0]      req_size;

  assign req_valid = exu_load_en | exu_store_en;
  assign req_store = exu_store_en;
  assign req_ea    = exu_store_en ? exu_store_addr : (exu_load_base_addr + exu_load_offset);
  assign req_size  = exu_store_en ? exu_store_size : exu_load_size;

  // Per-transfer context. Size and ea[1:0] are recovered from the held
  // hsize/haddr, so only rd, sext and the store data need capturing here.
  logic [4:0]      lat_rd;
  logic            lat_sext;
  logic [XLEN-1:0] lat_sdata;

  always_ff @(posedge hclk) begin
    if (state == ST_IDLE) begin
      lat_rd    <= exu_load_rd;
      lat_sext  <= exu_load_sext;
      lat_sdata <= exu_store_data;
    end
  end

  logic [XLEN-1:0] store_rep;
  logic [XLEN-1:0] load_val;

  lsu_lane_swc u_lane (
    .size       (hsize[1:0]),
    .ea_lo      (haddr[1:0]),
    .sext       (lat_sext),
    .store_data (lat_sdata),
    .rdata      (hrdata),
    .store_rep  (store_rep),
    .load_val   (load_val)
  );

  assign hburst = HBURST_SINGLE;
  assign hprot  = HPROT_VAL;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state         <= ST_IDLE;
      htrans        <= HTRANS_IDLE;
      haddr         <= '0;
      hwrite        <= 1'b0;
      hsize         <= 3'b000;
      hwdata        <= '0;
      lsu_reg_waddr <= 5'd0;
      lsu_reg_wdata <= '0;
      lsu_reg_wen   <= 1'b0;
      lsu_busy      <= 1'b0;
      lsu_misalign  <= 1'b0;
      lsu_bus_err   <= 1'b0;
    end else begin
      lsu_misalign <= 1'b0;
      lsu_bus_err  <= 1'b0;
      lsu_reg_wen  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_aligned(req_size, req_ea[1:0])) begin
              htrans   <= HTRANS_NONSEQ;
              haddr    <= req_ea;
              hwrite   <= req_store;
              hsize    <= {1'b0, req_size};
              lsu_busy <= 1'b1;
              state    <= ST_ADDR;
            end else begin
              lsu_misalign <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            htrans <= HTRANS_IDLE;
            if (hwrite) hwdata <= store_rep;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (hready) begin
            if (hresp) begin
              lsu_bus_err <= 1'b1;
              lsu_busy    <= 1'b0;
              state       <= ST_IDLE;
            end else if (!hwrite) begin
              lsu_reg_wdata <= load_val;
              lsu_reg_waddr <= lat_rd;
              // x0 is hardwired; the data is still captured but not written.
              lsu_reg_wen   <= (lat_rd != 5'd0);
              state         <= ST_WB;
            end else begin
              lsu_busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_WB: begin
          lsu_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          htrans   <= HTRANS_IDLE;
          lsu_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ahb_swc.sv
module tb_lsu_ahb_swc;

  logic        hclk;
  logic        hrst;
  logic        exu_load_en;
  logic [4:0]  exu_load_rd;
  logic [31:0] exu_load_base_addr;
  logic [31:0] exu_load_offset;
  logic        exu_load_sext;
  logic [1:0]  exu_load_size;
  logic        exu_store_en;
  logic [31:0] exu_store_addr;
  logic [31:0] exu_store_data;
  logic [1:0]  exu_store_size;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [4:0]  lsu_reg_waddr;
  logic [31:0] lsu_reg_wdata;
  logic        lsu_reg_wen;
  logic        lsu_busy;
  logic        lsu_misalign;
  logic        lsu_bus_err;

  int checks = 0;
  int errors = 0;

  lsu_ahb_swc dut (
    .hclk               (hclk),
    .hrst               (hrst),
    .exu_load_en        (exu_load_en),
    .exu_load_rd        (exu_load_rd),
    .exu_load_base_addr (exu_load_base_addr),
    .exu_load_offset    (exu_load_offset),
    .exu_load_sext      (exu_load_sext),
    .exu_load_size      (exu_load_size),
    .exu_store_en       (exu_store_en),
    .exu_store_addr     (exu_store_addr),
    .exu_store_data     (exu_store_data),
    .exu_store_size     (exu_store_size),
    .haddr              (haddr),
    .htrans             (htrans),
    .hwrite             (hwrite),
    .hsize              (hsize),
    .hburst             (hburst),
    .hprot              (hprot),
    .hwdata             (hwdata),
    .hrdata             (hrdata),
    .hready             (hready),
    .hresp              (hresp),
    .lsu_reg_waddr      (lsu_reg_waddr),
    .lsu_reg_wdata      (lsu_reg_wdata),
    .lsu_reg_wen        (lsu_reg_wen),
    .lsu_busy           (lsu_busy),
    .lsu_misalign       (lsu_misalign),
    .lsu_bus_err        (lsu_bus_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic clear_req();
    exu_load_en  = 1'b0;
    exu_store_en = 1'b0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [31:0] base,
                            input logic [31:0] off, input logic sext, input logic [1:0] size);
    exu_load_en        = 1'b1;
    exu_load_rd        = rd;
    exu_load_base_addr = base;
    exu_load_offset    = off;
    exu_load_sext      = sext;
    exu_load_size      = size;
  endtask

  task automatic issue_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size);
    exu_store_en   = 1'b1;
    exu_store_addr = addr;
    exu_store_data = data;
    exu_store_size = size;
  endtask

  task automatic test_reset();
    hrst = 1'b1;
    step();
    step();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got %h need %h", htrans, 2'b00); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr got %h need %h", haddr, 32'h0); end
    checks++; if (lsu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", lsu_busy); end
    checks++; if (lsu_reg_wen !== 1'b0 || lsu_reg_wdata !== 32'h0) begin errors++; $display("FAIL reset_reg got wen=%b wdata=%h need 0/0", lsu_reg_wen, lsu_reg_wdata); end
    checks++; if (hburst !== 3'b000 || hprot !== 4'b0011) begin errors++; $display("FAIL const_bus got hburst=%b hprot=%b need 000/0011", hburst, hprot); end
    hrst = 1'b0;
    step();
  endtask

  task automatic test_load_word();
    hready = 1'b1; hresp = 1'b0;
    issue_load(5'd9, 32'h0000_1000, 32'h0000_0004, 1'b0, 2'b10);   // T0
    step(); clear_req();                                             // T1
    checks++; if (htrans !== 2'b10 || haddr !== 32'h1004 || hsize !== 3'b010 || hwrite !== 1'b0) begin errors++; $display("FAIL lw_addr_phase got htrans=%b haddr=%h hsize=%b hwrite=%b need 10/00001004/010/0", htrans, haddr, hsize, hwrite); end
    checks++; if (lsu_busy !== 1'b1) begin errors++; $display("FAIL lw_busy got %b need 1", lsu_busy); end
    hrdata = 32'hDEAD_BEEF;
    step();                                                          // T2
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL lw_data_htrans got %b need 00", htrans); end
    checks++; if (lsu_reg_wen !== 1'b0) begin errors++; $display("FAIL lw_early_wen got %b need 0", lsu_reg_wen); end
    step();                                                          // T3
    checks++; if (lsu_reg_wen !== 1'b1 || lsu_reg_wdata !== 32'hDEAD_BEEF || lsu_reg_waddr !== 5'd9) begin errors++; $display("FAIL lw_wb got wen=%b wdata=%h waddr=%0d need 1/deadbeef/9", lsu_reg_wen, lsu_reg_wdata, lsu_reg_waddr); end
    step();                                                          // T4
    checks++; if (lsu_reg_wen !== 1'b0 || lsu_busy !== 1'b0) begin errors++; $display("FAIL lw_end got wen=%b busy=%b need 0/0", lsu_reg_wen, lsu_busy); end
  endtask

  task automatic test_load_byte(input logic sext, input logic [31:0] expected);
    hready = 1'b1; hresp = 1'b0;
    issue_load(5'd3, 32'h0000_1000, 32'h0000_0003, sext, 2'b00);
    step(); clear_req();
    checks++; if (haddr !== 32'h1003 || hsize !== 3'b000) begin errors++; $display("FAIL lb_addr sext=%b got haddr=%h hsize=%b need 00001003/000", sext, haddr, hsize); end
    hrdata = 32'h80FF_0000;
    step();
    step();
    checks++; if (lsu_reg_wen !== 1'b1 || lsu_reg_wdata !== expected) begin errors++; $display("FAIL lb_wdata sext=%b got wen=%b wdata=%h need 1/%h", sext, lsu_reg_wen, lsu_reg_wdata, expected); end
    step();
  endtask

  // lh from upper half into x0: data captured but write strobe suppressed.
  task automatic test_load_half_x0();
    hready = 1'b1; hresp = 1'b0;
    issue_load(5'd0, 32'h0000_2000, 32'h0000_0002, 1'b1, 2'b01);
    step(); clear_req();
    hrdata = 32'h8001_1234;
    step();
    step();
    checks++; if (lsu_reg_wen !== 1'b0 || lsu_reg_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_x0 got wen=%b wdata=%h need 0/ffff8001", lsu_reg_wen, lsu_reg_wdata); end
    step();
    checks++; if (lsu_busy !== 1'b0) begin errors++; $display("FAIL lh_x0_busy got %b need 0", lsu_busy); end
  endtask

  task automatic test_store_wait();
    int held = 0;
    bit wen_seen = 0;
    hresp = 1'b0;
    issue_store(32'h0000_2002, 32'h1234_ABCD, 2'b01);
    hready = 1'b1;
    step(); clear_req();                                             // T1
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (htrans === 2'b10 && haddr === 32'h2002 && hwrite === 1'b1 && hsize === 3'b001) held++;
      if (lsu_reg_wen === 1'b1) wen_seen = 1;
      if (i == 2) hready = 1'b1;
      step();
    end
    checks++; if (held != 3) begin errors++; $display("FAIL sh_addr_hold got %0d cycles need 3", held); end
    checks++; if (htrans !== 2'b00 || hwdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_data_phase got htrans=%b hwdata=%h need 00/abcdabcd", htrans, hwdata); end
    if (lsu_reg_wen === 1'b1) wen_seen = 1;
    step();
    if (lsu_reg_wen === 1'b1) wen_seen = 1;
    checks++; if (lsu_busy !== 1'b0) begin errors++; $display("FAIL sh_end_busy got %b need 0", lsu_busy); end
    checks++; if (wen_seen) begin errors++; $display("FAIL sh_no_wen got 1 need 0"); end
    checks++; if (hwdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_hwdata_hold got %h need abcdabcd", hwdata); end
  endtask

  // Simultaneous load and store: the store wins, byte data replicated.
  task automatic test_store_priority();
    hready = 1'b1; hresp = 1'b0;
    issue_load(5'd5, 32'h0000_1000, 32'h0, 1'b0, 2'b10);
    issue_store(32'h0000_3001, 32'hCAFE_005A, 2'b00);
    step(); clear_req();
    checks++; if (haddr !== 32'h3001 || hwrite !== 1'b1 || hsize !== 3'b000) begin errors++; $display("FAIL prio_addr got haddr=%h hwrite=%b hsize=%b need 00003001/1/000", haddr, hwrite, hsize); end
    step();
    checks++; if (hwdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sb_hwdata got %h need 5a5a5a5a", hwdata); end
    step();
    checks++; if (lsu_busy !== 1'b0 || lsu_reg_wen !== 1'b0) begin errors++; $display("FAIL prio_end got busy=%b wen=%b need 0/0", lsu_busy, lsu_reg_wen); end
  endtask

  task automatic test_misalign(input logic [31:0] base, input logic [1:0] size);
    bit busy_seen = 0;
    bit trans_seen = 0;
    hready = 1'b1; hresp = 1'b0;
    issue_load(5'd4, base, 32'h0, 1'b0, size);
    step(); clear_req();
    checks++; if (lsu_misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse ea=%h size=%b got %b need 1", base, size, lsu_misalign); end
    for (int i = 0; i < 3; i++) begin
      if (lsu_busy === 1'b1) busy_seen = 1;
      if (htrans !== 2'b00) trans_seen = 1;
      step();
      if (lsu_misalign !== 1'b0) busy_seen = 1;
    end
    checks++; if (busy_seen || trans_seen) begin errors++; $display("FAIL misalign_quiet ea=%h got busy_or_extra_pulse=%b trans=%b need 0/0", base, busy_seen, trans_seen); end
  endtask

  task automatic test_bus_err();
    hready = 1'b1; hresp = 1'b0;
    issue_load(5'd6, 32'h0000_4000, 32'h0, 1'b0, 2'b10);
    step(); clear_req();
    step();                                   // DATA
    hresp = 1'b1; hrdata = 32'h1111_2222;
    step();
    hresp = 1'b0;
    checks++; if (lsu_bus_err !== 1'b1 || lsu_reg_wen !== 1'b0 || lsu_busy !== 1'b0) begin errors++; $display("FAIL bus_err got err=%b wen=%b busy=%b need 1/0/0", lsu_bus_err, lsu_reg_wen, lsu_busy); end
    step();
    checks++; if (lsu_bus_err !== 1'b0 || lsu_reg_wen !== 1'b0 || lsu_reg_wdata === 32'h1111_2222) begin errors++; $display("FAIL bus_err_after got err=%b wen=%b wdata=%h need 0/0/not 11112222", lsu_bus_err, lsu_reg_wen, lsu_reg_wdata); end
  endtask

  task automatic test_reset_mid_store();
    hready = 1'b1; hresp = 1'b0;
    issue_store(32'h0000_5000, 32'h55AA_55AA, 2'b10);
    step(); clear_req();
    step();                                   // DATA, hwdata valid
    hready = 1'b0;
    checks++; if (hwdata !== 32'h55AA_55AA || lsu_busy !== 1'b1) begin errors++; $display("FAIL rst_pre got hwdata=%h busy=%b need 55aa55aa/1", hwdata, lsu_busy); end
    #2 hrst = 1'b1;
    #1;
    checks++; if (htrans !== 2'b00 || lsu_busy !== 1'b0 || hwdata !== 32'h0) begin errors++; $display("FAIL rst_async got htrans=%b busy=%b hwdata=%h need 00/0/00000000", htrans, lsu_busy, hwdata); end
    step();
    hrst = 1'b0; hready = 1'b1;
    step();
    issue_load(5'd7, 32'h0000_0040, 32'h0, 1'b0, 2'b10);
    step(); clear_req();
    checks++; if (htrans !== 2'b10 || haddr !== 32'h40) begin errors++; $display("FAIL rst_new_addr got htrans=%b haddr=%h need 10/00000040", htrans, haddr); end
    hrdata = 32'h0BAD_F00D;
    step();
    step();
    checks++; if (lsu_reg_wen !== 1'b1 || lsu_reg_wdata !== 32'h0BAD_F00D || lsu_reg_waddr !== 5'd7) begin errors++; $display("FAIL rst_new_wb got wen=%b wdata=%h waddr=%0d need 1/0badf00d/7", lsu_reg_wen, lsu_reg_wdata, lsu_reg_waddr); end
    step();
  endtask

  initial begin
    hrst = 1'b1;
    exu_load_en = 1'b0; exu_load_rd = 5'd0; exu_load_base_addr = 32'h0;
    exu_load_offset = 32'h0; exu_load_sext = 1'b0; exu_load_size = 2'b00;
    exu_store_en = 1'b0; exu_store_addr = 32'h0; exu_store_data = 32'h0;
    exu_store_size = 2'b00;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    #1;

    test_reset();
    test_load_word();
    test_load_byte(1'b1, 32'hFFFF_FF80);
    test_load_byte(1'b0, 32'h0000_0080);
    test_load_half_x0();
    test_store_wait();
    test_store_priority();
    test_misalign(32'h0000_1002, 2'b10);
    test_misalign(32'h0000_1000, 2'b11);
    test_bus_err();
    test_reset_mid_store();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
